// File: rtl/config_stream_loader_pkg.sv
// Shared types and field positions for the configuration stream loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package config_stream_loader_pkg;

    // Loader states; CHECK is only reachable when the trailer checksum is built in
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        DATA  = 3'd2,
        ISSUE = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Field positions inside config_addr
    localparam int MOD_ID_MSB  = 31;
    localparam int MOD_ID_LSB  = 16;
    localparam int TILE_ID_MSB = 15;
    localparam int TILE_ID_LSB = 0;

    // Mod id reserved for the idle bus; no tile matcher decodes it
    localparam logic [15:0] DEFAULT_IDLE_MOD_ID = 16'h0000;

endpackage

// File: rtl/config_stream_loader.sv
// Unpacks a header + N x {addr, data} stream into single writes on the shared config bus.
// Latency: write appears the cycle after its data beat, held HOLD_CYCLES; done one cycle after the last hold.
// Backpressure: in_ready drops while a write is held and in DONE. Optional trailer check: CONFIG_STREAM_LOADER_CHECKSUM_EN.
module config_stream_loader
    import config_stream_loader_pkg::*;
#(
    parameter int          HOLD_CYCLES = 1,
    parameter logic [15:0] IDLE_MOD_ID = DEFAULT_IDLE_MOD_ID,
    parameter int          COUNT_W     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] config_addr,
    output logic [31:0] config_data,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [31:0] IDLE_ADDR = {IDLE_MOD_ID, 16'h0000};
    localparam logic [3:0]  HOLD_LAST = 4'(HOLD_CYCLES - 1);

    state_t             state;
    logic [COUNT_W-1:0] pair_cnt;
    logic [3:0]         hold_cnt;
    logic [31:0]        addr_q;
`ifdef CONFIG_STREAM_LOADER_CHECKSUM_EN
    logic [31:0]        csum;
`endif

    logic accept;
    assign accept = in_valid && in_ready;

    // Packet FSM; every output is registered and set alongside the state it belongs to
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            in_ready    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            config_addr <= IDLE_ADDR;
            config_data <= 32'h0;
            pair_cnt    <= '0;
            hold_cnt    <= 4'd0;
            addr_q      <= 32'h0;
`ifdef CONFIG_STREAM_LOADER_CHECKSUM_EN
            csum        <= 32'h0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        pair_cnt <= in_data[COUNT_W-1:0];
                        busy     <= 1'b1;
`ifdef CONFIG_STREAM_LOADER_CHECKSUM_EN
                        csum     <= in_data;
`endif
                        if (in_data[COUNT_W-1:0] == '0) begin
                            state    <= DONE;
                            in_ready <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            state <= ADDR;
                        end
                    end
                end
                ADDR: begin
                    if (accept) begin
                        addr_q <= in_data;
                        state  <= DATA;
`ifdef CONFIG_STREAM_LOADER_CHECKSUM_EN
                        csum   <= csum ^ in_data;
`endif
                    end
                end
                DATA: begin
                    if (accept) begin
                        state    <= ISSUE;
                        in_ready <= 1'b0;
                        hold_cnt <= HOLD_LAST;
`ifdef CONFIG_STREAM_LOADER_CHECKSUM_EN
                        csum     <= csum ^ in_data;
`endif
                        // A reserved mod id would look like the idle bus: keep idle, flag it
                        if (addr_q[MOD_ID_MSB:MOD_ID_LSB] == IDLE_MOD_ID) begin
                            err <= 1'b1;
                        end else begin
                            config_addr <= addr_q;
                            config_data <= in_data;
                        end
                    end
                end
                ISSUE: begin
                    if (hold_cnt == 4'd0) begin
                        config_addr <= IDLE_ADDR;
                        config_data <= 32'h0;
                        if (pair_cnt != '0) begin
                            pair_cnt <= pair_cnt - COUNT_W'(1);
                        end
                        if (pair_cnt <= COUNT_W'(1)) begin
`ifdef CONFIG_STREAM_LOADER_CHECKSUM_EN
                            state    <= CHECK;
                            in_ready <= 1'b1;
`else
                            state    <= DONE;
                            done     <= 1'b1;
`endif
                        end else begin
                            state    <= ADDR;
                            in_ready <= 1'b1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt - 4'd1;
                    end
                end
`ifdef CONFIG_STREAM_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (accept) begin
                        if (in_data != csum) begin
                            err <= 1'b1;
                        end
                        state    <= DONE;
                        in_ready <= 1'b0;
                        done     <= 1'b1;
                    end
                end
`endif
                DONE: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    in_ready    <= 1'b0;
                    busy        <= 1'b0;
                    config_addr <= IDLE_ADDR;
                    config_data <= 32'h0;
                end
            endcase
        end
    end

endmodule

// File: doc/config_stream_loader.md
Name: config_stream_loader

Overview:
- Upstream feeder of the tile configuration bus.
- Accepts a packetised configuration stream on a 32-bit valid/ready input and unpacks it into {address, data} pairs.
- Drives the shared config_addr/config_data bus seen by every pe_tile's address matchers, one write at a time.
- Between writes, holds the bus at an address that no matcher decodes.

Parameters:
- HOLD_CYCLES, 1: cycles each write is held on config_addr/config_data (legal range 1..15).
- IDLE_MOD_ID, 0: mod-id value (addr[31:16]) driven when idle. It is reserved, and no tile matcher uses it.
- COUNT_W, 16: width of the pair-count field in the header beat.

Ports:
- clk  input  1  system clock
- reset  input  1  reset
- in_data  input  32  stream beat
- in_valid  input  1  beat valid
- in_ready  output  1  block accepts beat this cycle
- config_addr  output  32  [31:16] mod id / config flag, [15:0] tile id
- config_data  output  32  configuration payload
- busy  output  1  packet in progress (any state except IDLE)
- done  output  1  one-cycle pulse at end of packet
- err  output  1  sticky error flag

Behaviour:
- Clocking and reset: single clock clk; reset is synchronous and active-high.
- Reset values:
  - config_addr = {IDLE_MOD_ID, 16'h0000}, config_data = 0.
  - in_ready = 0 during the reset cycle, then 1 in IDLE.
  - busy = 0, done = 0, err = 0.
  - State is IDLE.
- Beat transfer: a beat transfers when in_valid && in_ready at the rising edge. All outputs are registered.
- Packet format: header beat (bits [COUNT_W-1:0] = N pairs, upper bits ignored), then N x (address beat, data beat).
- State machine:
  - IDLE: in_ready = 1. Header accepted: N = 0 -> DONE; otherwise load pair counter = N -> ADDR.
  - ADDR: in_ready = 1. Capture the address beat -> DATA.
  - DATA: in_ready = 1. Capture the data beat -> ISSUE.
  - ISSUE: in_ready = 0. Drive the captured address and data for exactly HOLD_CYCLES cycles, starting the cycle after the data beat is accepted. Then decrement the pair counter: 0 -> DONE (or CHECK, see Optional Feature); else -> ADDR.
  - DONE: done = 1 for one cycle, in_ready = 0 -> IDLE.
- Bus outside ISSUE: config_addr returns to the idle value and config_data to 0 on the cycle after ISSUE ends. There are no glitch cycles with a stale address.
- Reserved address:
  - Applies when the address beat's [31:16] == IDLE_MOD_ID.
  - The pair is consumed, but the bus stays idle for the HOLD_CYCLES slot.
  - err is set. The pair counter still decrements.
- err is cleared only by reset.
- Back-pressure: in_valid with in_ready low has no effect. The upstream block holds in_data stable.
- Reset mid-packet: the partial packet is discarded, the state machine goes to IDLE, and the bus returns to idle on the next cycle. The remainder of the old packet arriving later is parsed as a new header. The upstream block must restart its stream.
- Counter width: N up to 2^COUNT_W - 1. No wrap: the counter stops at 0.

Optional Feature:
- Macro: CONFIG_STREAM_LOADER_CHECKSUM_EN.
- When defined:
  - After the last pair, state CHECK (in_ready = 1) accepts one trailer beat.
  - The trailer is compared with the XOR of all beats in the packet, header included.
  - Mismatch sets err. CHECK then proceeds -> DONE.
- When undefined: no CHECK state, no trailer beat, and ISSUE goes directly to DONE.

Decomposition:
- Package config_stream_loader_pkg holds:
  - the state enum (IDLE, ADDR, DATA, ISSUE, CHECK, DONE);
  - MOD_ID_MSB = 31, MOD_ID_LSB = 16, TILE_ID_MSB = 15, TILE_ID_LSB = 0;
  - the default IDLE_MOD_ID.
- No sub-module is needed. The hold counter and pair counter are small enough to stay inline.

Test Plan:
- Single write:
  - Stimulus: reset, then stream 0x1, 0x0006_0000, 0x0000_0005 (in_valid held high).
  - Response: config_addr = 0x0006_0000 and config_data = 5 for 1 cycle, starting the cycle after the data beat; then idle; done pulses the next cycle.
- Hold length: with HOLD_CYCLES = 3, stream N = 2 with addrs 0x0004_0000 and 0x0007_0000.
  - Response: each address is held for exactly 3 cycles, with in_ready = 0 throughout each hold. done pulses once.
- Zero count: header 0x0.
  - Response: done pulses on the cycle after the header. config_addr never leaves 0x0000_0000.
- Reserved address: pair (0x0000_0012, 0xFF).
  - Response: bus stays idle, err rises and stays 1 through a subsequent good packet, done pulses.
- Reset mid-packet: assert reset for 1 cycle after the address beat of pair 1 of 3.
  - Response: next cycle busy = 0 and the bus is idle. A fresh 1-pair packet then completes normally.
- Checksum (CONFIG_STREAM_LOADER_CHECKSUM_EN):
  - Stream 0x1, 0x0005_0000, 0x3, trailer 0x0005_0002 -> err stays 0.
  - Same stream with trailer 0x0 -> err = 1.
  - done pulses in both cases.
